// File: rtl/udcnt_pkg.sv
// Shared constants and next-count selection for the up/down counter.
// Keeps the end-of-range decision in one place so the top only has to mux.
package udcnt_pkg;

    localparam logic UDCNT_UP   = 1'b1;
    localparam logic UDCNT_DOWN = 1'b0;
    localparam logic UDCNT_WRAP = 1'b0;
    localparam logic UDCNT_SAT  = 1'b1;

    typedef enum logic [1:0] {
        UDCNT_SEL_HOLD = 2'd0,
        UDCNT_SEL_STEP = 2'd1,
        UDCNT_SEL_LOW  = 2'd2,
        UDCNT_SEL_HIGH = 2'd3
    } udcnt_sel_e;

    // Width-independent: picks which value the count register takes on a step.
    function automatic udcnt_sel_e udcnt_next_sel(
        input logic step,
        input logic up,
        input logic sat_mode,
        input logic at_end
    );
        udcnt_sel_e sel;
        if (!step) begin
            sel = UDCNT_SEL_HOLD;
        end else if (!at_end) begin
            sel = UDCNT_SEL_STEP;
        end else if (sat_mode == UDCNT_SAT) begin
            sel = UDCNT_SEL_HOLD;
        end else if (up == UDCNT_UP) begin
            sel = UDCNT_SEL_LOW;
        end else begin
            sel = UDCNT_SEL_HIGH;
        end
        return sel;
    endfunction

endpackage

// File: rtl/updown_counter_n_incdec.sv
// Full-adder cell and the +/-1 ripple chain built from it.
// Decrement adds all-ones with carry-in 0; increment adds zero with carry-in 1.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module incdec_ripple #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             dec,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = ~dec;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fulladder u_fa (
            .a  (a[i]),
            .b  (dec),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end
endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with load, wrap/saturate at MAX_VAL and status flags.
// Define UDCNT_PRESCALE_EN to add a prescaler that takes one step every PRESCALE enabled cycles.
module updown_counter_n
    import udcnt_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_end,
    output logic             zero
);

    localparam logic FULL_RANGE = (MAX_VAL == {WIDTH{1'b1}});

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_val;
    logic             step_cout;
    logic             step;
    logic [WIDTH-1:0] load_clamped;
    udcnt_sel_e       sel;

    incdec_ripple #(.WIDTH(WIDTH)) u_incdec (
        .a    (count_q),
        .dec  (up == UDCNT_DOWN),
        .sum  (step_val),
        .cout (step_cout)
    );

    // Full range: the ripple carry already says whether the step would overflow.
    always_comb begin
        at_end = 1'b0;
        if (FULL_RANGE) begin
            at_end = (up == UDCNT_UP) ? step_cout : ~step_cout;
        end else begin
            at_end = (up == UDCNT_UP) ? (count_q == MAX_VAL) : (count_q == '0);
        end
    end

`ifdef UDCNT_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    assign step = en && (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign step = en;
`endif

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign sel          = udcnt_next_sel(step, up, sat_mode, at_end);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else begin
            case (sel)
                UDCNT_SEL_STEP: count_d = step_val;
                UDCNT_SEL_LOW: begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
                UDCNT_SEL_HIGH: begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign zero  = (count_q == '0);

endmodule
